// File: rtl/i2c_read_2pointer.sv
// I2C master reader for sensors with a 16-bit register pointer.
// Bus sequence: START, write address, POINTER[15:8], POINTER[7:0], repeated
// START, read address, DATA_BYTES data bytes (MSB first), STOP.
//
// Handshake: a rising edge of GO seen while idle (END_OK=1) starts one
// transaction. END_OK drops the cycle after that edge and returns high the
// cycle after STOP completes. GO edges while busy are ignored, and GO held
// high never retriggers.
//
// Each PT_CK cycle is one quarter-bit phase. SDAO/SCLO are registered from
// the next-state decode, so state_q always names the phase currently on
// the bus.
module i2c_read_2pointer #(
  parameter int DATA_BYTES = 2
) (
  input  logic        PT_CK,
  input  logic        RESET,
  input  logic        GO,
  input  logic [15:0] POINTER,
  input  logic [7:0]  SLAVE_ADDRESS,
  input  logic        SDAI,
  output logic        SDAO,
  output logic        SCLO,
  output logic        END_OK,
  output logic        ACK_OK,
  output logic [15:0] DATA,
  output logic [7:0]  ST
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_TX_BYTE = 4'd2,
    S_TX_ACK  = 4'd3,
    S_RSTART  = 4'd4,
    S_RX_BYTE = 4'd5,
    S_RX_ACK  = 4'd6,
    S_STOP    = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  // Index of the final data byte; its ACK slot carries the master NACK.
  localparam logic [1:0] LAST_RX = (DATA_BYTES == 1) ? 2'd0 : 2'd1;

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;       // quarter-bit phase within a slot
  logic [2:0]  bit_q, bit_d;     // bit index within a byte
  logic [1:0]  byte_q, byte_d;   // tx: 0..3 (addr, ptr hi, ptr lo, read addr); rx: data byte
  logic        go_q;
  logic [15:0] ptr_q, ptr_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] rx_q, rx_d;
  logic        ack_ok_q, ack_ok_d;
  logic [15:0] data_q, data_d;
  logic        end_ok_q, end_ok_d;
  logic        sda_q, sda_d;
  logic        scl_q, scl_d;
  logic        start;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  // The R/W bit of SLAVE_ADDRESS is replaced by the sequence itself.
  logic        unused_addr_lsb;
  assign unused_addr_lsb = SLAVE_ADDRESS[0];

  // Next-state, counters, data capture and next bus levels.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    rx_d     = rx_q;
    ack_ok_d = ack_ok_q;
    data_d   = data_q;
    start    = GO && !go_q && (state_q == S_IDLE);

    if (state_q != S_IDLE && state_q != S_DONE) ph_d = ph_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_START;
          ph_d     = 2'd0;
          ptr_d    = POINTER;
          addr_d   = SLAVE_ADDRESS[7:1];
          ack_ok_d = 1'b1;
        end
      end
      S_START: begin
        if (ph_q == 2'd1) begin
          state_d = S_TX_BYTE;
          ph_d    = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end
      end
      S_TX_BYTE: begin
        if (ph_q == 2'd3) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_TX_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_TX_ACK: begin
        if (ph_q == 2'd3) begin
          if (SDAI) begin
            ack_ok_d = 1'b0;
            state_d  = S_STOP;
          end else begin
            case (byte_q)
              2'd2: state_d = S_RSTART;
              2'd3: begin
                state_d = S_RX_BYTE;
                byte_d  = 2'd0;
              end
              default: begin
                state_d = S_TX_BYTE;
                byte_d  = byte_q + 2'd1;
              end
            endcase
          end
        end
      end
      S_RSTART: begin
        if (ph_q == 2'd3) begin
          state_d = S_TX_BYTE;
          byte_d  = 2'd3;
          bit_d   = 3'd0;
        end
      end
      S_RX_BYTE: begin
        if (ph_q == 2'd3) begin
          rx_d = {rx_q[14:0], SDAI};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_RX_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_RX_ACK: begin
        if (ph_q == 2'd3) begin
          if (byte_q == LAST_RX) begin
            state_d = S_STOP;
          end else begin
            state_d = S_RX_BYTE;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (ph_q == 2'd3) begin
          state_d = S_DONE;
          // ACK_OK is still 1 only when every slave ACK slot was low.
          if (ack_ok_q) data_d = (DATA_BYTES == 1) ? {8'h00, rx_q[7:0]} : rx_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    end_ok_d = (state_d == S_IDLE) || (state_d == S_DONE);

    case (byte_d)
      2'd0:    tx_byte = {addr_d, 1'b0};
      2'd1:    tx_byte = ptr_d[15:8];
      2'd2:    tx_byte = ptr_d[7:0];
      default: tx_byte = {addr_d, 1'b1};
    endcase
    tx_bit = tx_byte[3'd7 - bit_d];

    // SDA only moves at P1 (SCL low) inside slots; P0 keeps the old level.
    sda_d = sda_q;
    scl_d = 1'b1;
    case (state_d)
      S_START: sda_d = (ph_d == 2'd0);
      S_TX_BYTE: begin
        scl_d = ph_d[1];
        if (ph_d != 2'd0) sda_d = tx_bit;
      end
      S_TX_ACK, S_RX_BYTE: begin
        scl_d = ph_d[1];
        if (ph_d != 2'd0) sda_d = 1'b1;
      end
      S_RX_ACK: begin
        scl_d = ph_d[1];
        if (ph_d != 2'd0) sda_d = (byte_d == LAST_RX);
      end
      S_RSTART: begin
        scl_d = ph_d[1];
        if (ph_d != 2'd0) sda_d = (ph_d != 2'd3);
      end
      S_STOP: begin
        scl_d = ph_d[1];
        if (ph_d != 2'd0) sda_d = (ph_d == 2'd3);
      end
      default: begin
        sda_d = 1'b1;
        scl_d = 1'b1;
      end
    endcase
  end

  // State, datapath and registered bus outputs.
  always_ff @(posedge PT_CK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      ph_q     <= 2'd0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      go_q     <= 1'b0;
      ptr_q    <= 16'h0000;
      addr_q   <= 7'h00;
      rx_q     <= 16'h0000;
      ack_ok_q <= 1'b0;
      data_q   <= 16'h0000;
      end_ok_q <= 1'b1;
      sda_q    <= 1'b1;
      scl_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      go_q     <= GO;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      rx_q     <= rx_d;
      ack_ok_q <= ack_ok_d;
      data_q   <= data_d;
      end_ok_q <= end_ok_d;
      sda_q    <= sda_d;
      scl_q    <= scl_d;
    end
  end

  assign SDAO   = sda_q;
  assign SCLO   = scl_q;
  assign END_OK = end_ok_q;
  assign ACK_OK = ack_ok_q;
  assign DATA   = data_q;
  assign ST     = {4'h0, state_q};

endmodule

// File: tb/tb_i2c_read_2pointer.sv
// Bench for i2c_read_2pointer: a 2-byte and a 1-byte reader share GO,
// POINTER and SLAVE_ADDRESS; each has its own bus monitor and slave model.
module tb_i2c_read_2pointer;

  localparam logic [9:0] EV_START = 10'h200;
  localparam logic [9:0] EV_STOP  = 10'h201;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [15:0] pointer = 16'h0000;
  logic [7:0]  slave_address = 8'h00;

  logic        sdao [2];
  logic        sclo [2];
  logic        end_ok [2];
  logic        ack_ok [2];
  logic        sdai [2];
  logic [15:0] data [2];
  logic [7:0]  st_unused [2];

  // Slave model / monitor state, one set per reader.
  logic        slave_sda [2] = '{1'b1, 1'b1};
  logic        p_sda [2] = '{1'b1, 1'b1};
  logic        p_scl [2] = '{1'b1, 1'b1};
  logic        s_read [2] = '{1'b0, 1'b0};
  logic        s_act [2] = '{1'b0, 1'b0};
  logic [7:0]  s_sh [2] = '{8'h00, 8'h00};
  int          s_pos [2] = '{0, 0};
  int          s_nb [2] = '{0, 0};
  int          ack_cnt [2] = '{0, 0};
  int          low_cnt [2] = '{0, 0};
  int          scl_tog [2] = '{0, 0};
  int          proto_err [2] = '{0, 0};
  logic        mon_en = 1'b0;
  logic [7:0]  rd_b [2] = '{8'h00, 8'h00};
  int          nack_at = -1;

  logic [9:0]  obs_q0[$];
  logic [9:0]  obs_q1[$];
  logic [9:0]  exp_q0[$];
  logic [9:0]  exp_q1[$];
  logic [15:0] exp_data [2] = '{16'h0000, 16'h0000};

  int checks = 0;
  int failures = 0;

  // Clock and SDA wired-AND with the slave.
  always #5 clk = ~clk;
  assign sdai[0] = sdao[0] & slave_sda[0];
  assign sdai[1] = sdao[1] & slave_sda[1];

  i2c_read_2pointer #(.DATA_BYTES(2)) dut2 (
    .PT_CK(clk), .RESET(rst), .GO(go), .POINTER(pointer),
    .SLAVE_ADDRESS(slave_address), .SDAI(sdai[0]), .SDAO(sdao[0]),
    .SCLO(sclo[0]), .END_OK(end_ok[0]), .ACK_OK(ack_ok[0]),
    .DATA(data[0]), .ST(st_unused[0])
  );

  i2c_read_2pointer #(.DATA_BYTES(1)) dut1 (
    .PT_CK(clk), .RESET(rst), .GO(go), .POINTER(pointer),
    .SLAVE_ADDRESS(slave_address), .SDAI(sdai[1]), .SDAO(sdao[1]),
    .SCLO(sclo[1]), .END_OK(end_ok[1]), .ACK_OK(ack_ok[1]),
    .DATA(data[1]), .ST(st_unused[1])
  );

  function automatic int nbytes(int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic void push_obs(int u, logic [9:0] v);
    if (u == 0) obs_q0.push_back(v);
    else obs_q1.push_back(v);
  endfunction

  function automatic void push_exp(int u, logic [9:0] v);
    if (u == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endfunction

  // Bus monitor and slave: samples both readers away from the active edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic       line;
      logic [7:0] byt;
      if (!end_ok[u]) low_cnt[u]++;
      if (sclo[u] != p_scl[u]) scl_tog[u]++;
      if (mon_en) begin
        if (sclo[u] != p_scl[u] && sdao[u] != p_sda[u]) begin
          proto_err[u]++;
        end else if (p_scl[u] && sclo[u] && sdao[u] != p_sda[u]) begin
          if (!sdao[u]) begin
            push_obs(u, EV_START);
            s_act[u] = 1'b1; s_pos[u] = 0; s_nb[u] = 0; s_read[u] = 1'b0;
          end else begin
            push_obs(u, EV_STOP);
            s_act[u] = 1'b0; slave_sda[u] = 1'b1;
          end
        end else if (!p_scl[u] && sclo[u] && s_act[u]) begin
          line = sdao[u] & slave_sda[u];
          if (s_pos[u] < 8) begin
            s_sh[u] = {s_sh[u][6:0], line};
            s_pos[u]++;
          end else begin
            push_obs(u, {1'b0, s_sh[u], line});
            if (s_nb[u] == 0) s_read[u] = s_sh[u][0];
            s_nb[u]++;
            s_pos[u] = 0;
          end
        end else if (p_scl[u] && !sclo[u] && s_act[u]) begin
          if (s_pos[u] == 8) begin
            if (s_nb[u] == 0 || !s_read[u]) begin
              slave_sda[u] = (ack_cnt[u] == nack_at) ? 1'b1 : 1'b0;
              ack_cnt[u]++;
            end else begin
              slave_sda[u] = 1'b1;
            end
          end else if (s_read[u] && s_nb[u] >= 1 && s_nb[u] <= nbytes(u)) begin
            byt = rd_b[s_nb[u] - 1];
            slave_sda[u] = byt[7 - s_pos[u]];
          end else begin
            slave_sda[u] = 1'b1;
          end
        end
      end
      p_scl[u] = sclo[u];
      p_sda[u] = sdao[u];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the bus event list a transaction must produce.
  function automatic void build_exp(int u, logic [7:0] sa, logic [15:0] ptr,
                                    logic [7:0] b0, logic [7:0] b1, int nack);
    logic [7:0] txb [4];
    logic [7:0] rxb [2];
    txb[0] = {sa[7:1], 1'b0};
    txb[1] = ptr[15:8];
    txb[2] = ptr[7:0];
    txb[3] = {sa[7:1], 1'b1};
    rxb[0] = b0;
    rxb[1] = b1;
    push_exp(u, EV_START);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) push_exp(u, EV_START);
      push_exp(u, {1'b0, txb[k], (nack == k)});
      if (nack == k) begin
        push_exp(u, EV_STOP);
        return;
      end
    end
    for (int i = 0; i < nbytes(u); i++)
      push_exp(u, {1'b0, rxb[i], (i == nbytes(u) - 1)});
    push_exp(u, EV_STOP);
  endfunction

  function automatic int exp_lat(int u, int nack);
    if (nack < 0) return 2 + 36 * 4 + 4 + 36 * nbytes(u) + 4;
    return 2 + 36 * (nack + 1) + 4 + ((nack == 3) ? 4 : 0);
  endfunction

  task automatic run_txn(input logic [7:0] sa, input logic [15:0] ptr,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input int nack, input bit hold, input bit mid_pulse);
    bit done = 1'b0;
    exp_q0.delete(); exp_q1.delete(); obs_q0.delete(); obs_q1.delete();
    for (int u = 0; u < 2; u++) begin
      build_exp(u, sa, ptr, b0, b1, nack);
      ack_cnt[u] = 0; low_cnt[u] = 0; proto_err[u] = 0;
    end
    if (nack < 0) begin
      exp_data[0] = {b0, b1};
      exp_data[1] = {8'h00, b0};
    end
    slave_address = sa; pointer = ptr; rd_b[0] = b0; rd_b[1] = b1; nack_at = nack;
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 2 && !hold) go = 1'b0;
      if (cyc == 3) begin
        slave_address = ~sa;
        pointer = ~ptr;
      end
      if (mid_pulse && cyc == 60) go = 1'b1;
      if (mid_pulse && cyc == 62) go = 1'b0;
      if (low_cnt[0] > 0 && low_cnt[1] > 0 && end_ok[0] && end_ok[1]) done = 1'b1;
    end
    check("done_in_time", {31'd0, done}, 32'd1);
    repeat (40) @(negedge clk);
    go = 1'b0;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_end_ok", u), {31'd0, end_ok[u]}, 32'd1);
      check($sformatf("u%0d_ack_ok", u), {31'd0, ack_ok[u]}, {31'd0, (nack < 0)});
      check($sformatf("u%0d_data", u), {16'd0, data[u]}, {16'd0, exp_data[u]});
      check($sformatf("u%0d_busy_cycles", u), low_cnt[u], exp_lat(u, nack));
      check($sformatf("u%0d_sda_scl_together", u), proto_err[u], 0);
    end
    check("u0_event_count", obs_q0.size(), exp_q0.size());
    for (int i = 0; i < exp_q0.size() && i < obs_q0.size(); i++)
      check($sformatf("u0_event%0d", i), {22'd0, obs_q0[i]}, {22'd0, exp_q0[i]});
    check("u1_event_count", obs_q1.size(), exp_q1.size());
    for (int i = 0; i < exp_q1.size() && i < obs_q1.size(); i++)
      check($sformatf("u1_event%0d", i), {22'd0, obs_q1[i]}, {22'd0, exp_q1[i]});
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s_u%0d_sdao", tag, u), {31'd0, sdao[u]}, 32'd1);
      check($sformatf("%s_u%0d_sclo", tag, u), {31'd0, sclo[u]}, 32'd1);
      check($sformatf("%s_u%0d_end_ok", tag, u), {31'd0, end_ok[u]}, 32'd1);
      check($sformatf("%s_u%0d_ack_ok", tag, u), {31'd0, ack_ok[u]}, 32'd0);
      check($sformatf("%s_u%0d_data", tag, u), {16'd0, data[u]}, 32'd0);
    end
  endtask

  // Directed and randomized steps.
  initial begin
    logic [7:0]  r_sa;
    logic [15:0] r_ptr;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;
    int          sel;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    mon_en = 1'b1;

    // Nominal read, then the 1-byte variant's own value.
    run_txn(8'h6C, 16'h300A, 8'h88, 8'h65, -1, 1'b0, 1'b0);
    run_txn(8'h6C, 16'h300A, 8'h5A, 8'hC3, -1, 1'b0, 1'b0);
    // Address NACK: DATA must keep its previous value.
    run_txn(8'h6C, 16'h300A, 8'h11, 8'h22, 0, 1'b0, 1'b0);
    // GO held high across completion, then a GO pulse while busy.
    run_txn(8'h20, 16'h0102, 8'h01, 8'h80, -1, 1'b1, 1'b0);
    run_txn(8'h21, 16'hFFFF, 8'hFF, 8'h00, -1, 1'b0, 1'b1);
    // NACK on each remaining ACK slot.
    run_txn(8'h42, 16'hA55A, 8'h33, 8'h44, 1, 1'b0, 1'b0);
    run_txn(8'h42, 16'hA55A, 8'h33, 8'h44, 2, 1'b0, 1'b0);
    run_txn(8'h43, 16'h5AA5, 8'h55, 8'h66, 3, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      r_sa  = 8'($urandom_range(0, 255));
      r_ptr = 16'($urandom);
      r_b0  = 8'($urandom);
      r_b1  = 8'($urandom);
      sel   = $urandom_range(0, 7);
      run_txn(r_sa, r_ptr, r_b0, r_b1, (sel < 4) ? sel : -1, 1'b0, 1'b0);
    end

    // Reset in the middle of a transaction.
    slave_address = 8'h6C; pointer = 16'h300A; rd_b[0] = 8'h88; rd_b[1] = 8'h65; nack_at = -1;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    repeat (60) @(negedge clk);
    go = 1'b0;
    mon_en = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midreset");
    scl_tog[0] = 0; scl_tog[1] = 0;
    repeat (50) @(negedge clk);
    check("u0_scl_quiet_after_reset", scl_tog[0], 0);
    check("u1_scl_quiet_after_reset", scl_tog[1], 0);
    for (int u = 0; u < 2; u++) begin
      slave_sda[u] = 1'b1; s_act[u] = 1'b0; s_pos[u] = 0; s_nb[u] = 0;
      exp_data[u] = 16'h0000;
    end
    mon_en = 1'b1;
    run_txn(8'h6C, 16'h300A, 8'h88, 8'h65, -1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_read_2pointer.md
Name: i2c_read_2pointer

Overview:
I2C master reader for 16-bit-register-address sensors/bridges on the MIPI camera configuration bus. It is the read counterpart of the 2-pointer I2C write block and shares its bus timing, clocking and GO/END_OK handshake. Sequence: START, write-address byte, POINTER[15:8], POINTER[7:0], repeated START, read-address byte, DATA_BYTES data bytes (MSB first), STOP. The configuration sequencer uses it for readback and ID checks, muxing SDAO/SCLO with the writer.

Parameters:
DATA_BYTES, 2, number of data bytes read (legal values 1 or 2).

Ports:
PT_CK  input  1  bus-phase clock; each cycle is one quarter-bit phase.
RESET  input  1  synchronous, active-high reset.
GO  input  1  start request; acted on at its rising edge only.
POINTER  input  16  register address; sampled at the start edge.
SLAVE_ADDRESS  input  8  7-bit address in [7:1]; bit 0 ignored; sampled at the start edge.
SDAI  input  1  SDA line readback.
SDAO  output  1  SDA drive (1 = released/high).
SCLO  output  1  SCL drive.
END_OK  output  1  1 = idle/done; 0 = busy.
ACK_OK  output  1  1 = every slave ACK slot sampled low in the last transaction.
DATA  output  16  read result; with DATA_BYTES=1 result is in [7:0] and [15:8]=0.
ST  output  8  state code, test visibility only.

Behaviour:
- Reset (sync, PT_CK): SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, DATA=0, ST=IDLE, GO edge register=0. Applies mid-transaction; no STOP is generated. The next GO issues a fresh START. Bus recovery is out of scope.
- GO edge: a registered GO_d gives start = GO & !GO_d, evaluated only in IDLE.
  - Rising edges while busy are ignored.
  - Holding GO high does not retrigger.
- On start (cycle 0):
  - Latch POINTER and SLAVE_ADDRESS.
  - Clear ACK_OK to 1 (provisional).
  - Clear END_OK at cycle 1.
- START (2 cycles): SDAO=1/SCLO=1, then SDAO=0 with SCLO=1.
- Bit slot (4 cycles):
  - P0: SCLO=0.
  - P1: SDAO = bit (or 1 when receiving).
  - P2: SCLO=1.
  - P3: SCLO=1; sample SDAI.
- Byte (36 cycles): 8 bit slots plus 1 ACK slot.
  - Transmit bytes: SDAO=1 in the ACK slot; SDAI sampled at P3.
  - Write address = {SLAVE_ADDRESS[7:1],0}; read address = {SLAVE_ADDRESS[7:1],1}.
- Repeated START (4 cycles): SCLO=0; SDAO=1; SCLO=1; SDAO=0.
- Data bytes:
  - SDAO=1 for all 8 bits; shift SDAI in MSB first.
  - ACK slot drives SDAO=0 (master ACK) except after the last byte, which drives SDAO=1 (NACK).
- STOP (4 cycles): SCLO=0; SDAO=0; SCLO=1; SDAO=1.
- DATA update: only on successful completion. DATA is loaded from the shift register in the STOP's final cycle, and END_OK=1 is asserted in the next cycle.
- Latency, END_OK low to END_OK high: 226 cycles for DATA_BYTES=2; 190 cycles for DATA_BYTES=1.
- Slave NACK (SDAI=1 at P3 of any of the 4 address/pointer ACK slots):
  - ACK_OK<=0.
  - The next cycle goes directly to STOP, and END_OK=1 after it.
  - DATA is unchanged.
  - No retry; the sequencer re-issues GO for polling.
- Master never drives SDAO low while receiving data bits. SCL is never stretched (no clock-stretch detection).
- State set: IDLE, START, TX_BYTE, TX_ACK, RSTART, RX_BYTE, RX_ACK, STOP, DONE. Bit and byte counters wrap to 0 on each byte/phase boundary.

Test Plan:
- Reset: hold RESET=1 mid-byte of a transaction, release -> SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, DATA=0 next cycle; no SCL toggles until the next GO edge.
- Nominal read: SLAVE_ADDRESS=0x6C, POINTER=0x300A, slave model ACKs all and returns 0x88,0x65 -> bus bytes 0x6C,0x30,0x0A, Sr, 0x6D; master ACK after 0x88, NACK after 0x65; STOP; DATA=0x8865, ACK_OK=1; END_OK low for exactly 226 cycles.
- DATA_BYTES=1: same stimulus, slave returns 0x5A -> DATA=0x005A, NACK on the only byte, END_OK low 190 cycles.
- Address NACK: slave releases SDA on the first ACK slot -> ACK_OK=0, STOP follows immediately (no pointer bytes), END_OK=1, DATA keeps its previous value.
- GO handling: GO held high across completion -> exactly one transaction. A GO pulse while busy -> ignored. A GO low-then-high after END_OK=1 -> a second transaction starts.
- Protocol checker throughout: SDA changes only while SCL low, except START/Sr/STOP edges; read-address byte LSB=1, write-address byte LSB=0.
